// File: rtl/bit_window_unpacker_pkg.sv
// Shared inflate constants for the bit window unpacker and its consumers.
package bit_window_unpacker_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WIN    = 32;
  localparam int unsigned OUT_W  = 16;

  localparam int unsigned CNT_W = $clog2(WIN + 1);
  localparam int unsigned LEN_W = $clog2(OUT_W + 1);
  // Consume plus align can drop up to OUT_W + 7 bits in one cycle.
  localparam int unsigned SH_W  = $clog2(OUT_W + BYTE_W);

  typedef logic [LEN_W-1:0] consume_len_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bit_window_shift.sv
// Combinational right shifter shared by the consume and align paths.
module bit_window_shift #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SH_W-1:0]   amt,
  output logic [DATA_W-1:0] result
);

  assign result = data >> amt;

endmodule

// File: rtl/bit_window_unpacker.sv
// LSB-first bit window fed from a FWFT byte FIFO; supports consume, byte align and flush.
module bit_window_unpacker
  import bit_window_unpacker_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [7:0]         fifo_rdata,
  input  logic               fifo_rempty,
  output logic               fifo_rinc,
  output logic [OUT_W-1:0]   bits,
  output logic [CNT_W-1:0]   bits_avail,
  input  logic               consume,
  input  consume_len_t       consume_len,
  input  logic               align,
  output logic               err,
  output logic [31:0]        bytes_in
);

  localparam cnt_t FillMax = cnt_t'(WIN - BYTE_W);

  logic [WIN-1:0]  buf_q, buf_d, shifted, ins;
  cnt_t            cnt_q, cnt_d, len_ext, c1, c2;
  logic [2:0]      drop;
  logic [SH_W-1:0] amt;
  logic            cons_ok, pop, err_q, err_d;
  logic [31:0]     bytes_q, bytes_d;

  // Consume and align fold into one shift amount so a single shifter serves both.
  always_comb begin
    len_ext = cnt_t'(consume_len);
    cons_ok = consume && (len_ext <= cnt_q);
    c1      = cons_ok ? cnt_q - len_ext : cnt_q;
    drop    = align ? c1[2:0] : 3'd0;
    c2      = c1 - cnt_t'(drop);
    amt     = (cons_ok ? SH_W'(consume_len) : '0) + SH_W'(drop);
    pop     = !rst && !flush && !fifo_rempty && (c2 <= FillMax);
  end

  bit_window_shift #(
    .DATA_W (WIN),
    .SH_W   (SH_W)
  ) u_shift (
    .data   (buf_q),
    .amt    (amt),
    .result (shifted)
  );

  always_comb begin
    ins     = WIN'(fifo_rdata) << c2;
    buf_d   = pop ? (shifted | ins) : shifted;
    cnt_d   = pop ? c2 + cnt_t'(BYTE_W) : c2;
    err_d   = err_q | (consume && !cons_ok);
    bytes_d = pop ? bytes_q + 32'd1 : bytes_q;
    // Flush wins over everything, including a would-be underflow.
    if (flush) begin
      buf_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      bytes_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bytes_q <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bytes_q <= bytes_d;
    end
  end

  assign fifo_rinc  = pop;
  assign bits       = buf_q[OUT_W-1:0];
  assign bits_avail = cnt_q;
  assign err        = err_q;
  assign bytes_in   = bytes_q;

endmodule

// File: tb/tb_bit_window_unpacker.sv
// Randomized self-checking bench against a bit-queue reference model.
module tb_bit_window_unpacker;
  import bit_window_unpacker_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic [7:0]         fifo_rdata = 8'h00;
  logic               fifo_rempty = 1'b1;
  logic               fifo_rinc;
  logic [OUT_W-1:0]   bits;
  logic [CNT_W-1:0]   bits_avail;
  logic               consume = 1'b0;
  consume_len_t       consume_len = '0;
  logic               align = 1'b0;
  logic               err;
  logic [31:0]        bytes_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: stream bits in order, FIFO contents, counters.
  bit          mq[$];
  logic [7:0]  fq[$];
  int unsigned m_bytes = 0;
  bit          m_err = 1'b0;

  bit_window_unpacker u_dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .bits        (bits),
    .bits_avail  (bits_avail),
    .consume     (consume),
    .consume_len (consume_len),
    .align       (align),
    .err         (err),
    .bytes_in    (bytes_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_bits();
    logic [OUT_W-1:0] r = '0;
    for (int i = 0; i < OUT_W; i++) if (i < mq.size()) r[i] = mq[i];
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_bits"},  64'(bits),       64'(model_bits()));
    check({tag, "_avail"}, 64'(bits_avail), 64'(mq.size()));
    check({tag, "_err"},   64'(err),        64'(m_err));
    check({tag, "_bytes"}, 64'(bytes_in),   64'(m_bytes));
  endtask

  // One clock cycle: drive inputs, check the pop strobe, clock, update model, check state.
  task automatic step(input bit cons, input int len, input bit aln, input bit fl, input string tag);
    int  c;
    bit  exp_pop;
    logic [7:0] head;
    consume     = cons;
    consume_len = consume_len_t'(len);
    align       = aln;
    flush       = fl;
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() != 0) ? fq[0] : 8'($urandom);
    c = mq.size();
    if (cons && len <= c) c -= len;
    if (aln) c -= c % 8;
    exp_pop = !fl && fq.size() != 0 && c <= int'(WIN) - 8;
    #1;
    check({tag, "_rinc"}, 64'(fifo_rinc), 64'(exp_pop));
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_bytes = 0;
      m_err   = 1'b0;
    end else begin
      if (cons) begin
        if (len <= mq.size()) repeat (len) void'(mq.pop_front());
        else m_err = 1'b1;
      end
      if (aln) repeat (mq.size() % 8) void'(mq.pop_front());
      if (exp_pop) begin
        head = fq.pop_front();
        for (int i = 0; i < 8; i++) mq.push_back(head[i]);
        m_bytes++;
      end
    end
    consume = 1'b0;
    align   = 1'b0;
    flush   = 1'b0;
    check_state(tag);
  endtask

  initial begin
    int len;
    #12;
    check("rst_bits", 64'(bits), 64'h0);
    check("rst_avail", 64'(bits_avail), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_bytes", 64'(bytes_in), 64'h0);
    check("rst_rinc", 64'(fifo_rinc), 64'h0);
    #6 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    repeat (3) step(0, 0, 0, 0, "fill");
    check("fill_bits_k", 64'(bits), 64'h3CA5);
    check("fill_avail_k", 64'(bits_avail), 64'd16);
    check("fill_bytes_k", 64'(bytes_in), 64'd2);

    // Consume then align, then both in one cycle
    step(1, 3, 0, 0, "cons3");
    check("cons3_bits_k", 64'(bits), 64'h0794);
    check("cons3_avail_k", 64'(bits_avail), 64'd13);
    step(0, 0, 1, 0, "align");
    check("align_bits_k", 64'(bits), 64'h003C);
    check("align_avail_k", 64'(bits_avail), 64'd8);
    step(0, 0, 0, 1, "flush0");
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    repeat (2) step(0, 0, 0, 0, "refill");
    step(1, 3, 1, 0, "consalign");
    check("consalign_bits_k", 64'(bits), 64'h003C);
    check("consalign_avail_k", 64'(bits_avail), 64'd8);

    // Saturation
    step(0, 0, 0, 1, "flush1");
    repeat (8) fq.push_back(8'($urandom));
    repeat (5) step(0, 0, 0, 0, "sat");
    check("sat_avail_k", 64'(bits_avail), 64'd32);
    step(1, 1, 0, 0, "sat_c1");
    check("sat_c1_avail_k", 64'(bits_avail), 64'd31);
    step(1, 7, 0, 0, "sat_c7");
    step(1, 8, 0, 0, "sat_c8");
    check("sat_c8_avail_k", 64'(bits_avail), 64'd32);

    // Underflow
    step(0, 0, 0, 1, "flush2");
    fq.delete();
    fq.push_back(8'h5A);
    step(0, 0, 0, 0, "uf_fill");
    step(1, 9, 0, 0, "uf");
    check("uf_err_k", 64'(err), 64'd1);
    check("uf_avail_k", 64'(bits_avail), 64'd8);
    step(1, 0, 0, 0, "uf_sticky");
    step(0, 0, 0, 1, "uf_flush");
    check("uf_flush_err_k", 64'(err), 64'd0);

    // Flush mid-stream at cnt=20
    repeat (3) fq.push_back(8'($urandom));
    repeat (3) step(0, 0, 0, 0, "fm_fill");
    step(1, 4, 0, 0, "fm_c4");
    check("fm_avail20_k", 64'(bits_avail), 64'd20);
    fq.push_back(8'hC3);
    step(1, 5, 0, 1, "fm_flush");
    check("fm_bits_k", 64'(bits), 64'd0);
    check("fm_avail_k", 64'(bits_avail), 64'd0);

    // Async reset between edges
    fq.push_back(8'h96);
    repeat (2) step(0, 0, 0, 0, "ar_fill");
    check("ar_avail16_k", 64'(bits_avail), 64'd16);
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fifo_rempty = 1'b0;
    fifo_rdata  = fq[0];
    #2 rst = 1'b1;
    #1;
    check("ar_bits", 64'(bits), 64'd0);
    check("ar_avail", 64'(bits_avail), 64'd0);
    check("ar_bytes", 64'(bytes_in), 64'd0);
    check("ar_rinc", 64'(fifo_rinc), 64'd0);
    mq.delete();
    m_bytes = 0;
    m_err   = 1'b0;
    #1 rst = 1'b0;
    repeat (2) step(0, 0, 0, 0, "ar_resume");
    check("ar_resume_bits_k", 64'(bits), 64'h2211);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 3) != 0 && fq.size() < 12) fq.push_back(8'($urandom));
      if (($urandom % 16) == 0) len = $urandom_range(0, OUT_W);
      else len = $urandom_range(0, (mq.size() < OUT_W) ? mq.size() : OUT_W);
      step(($urandom % 4) != 0, len, ($urandom % 8) == 0, ($urandom % 50) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
